max7219_chain_driver: RTL and testbench

- Parametrised successor to the single-display output wrapper.
- Drives a daisy-chain of NUM_DEV MAX7219 devices over a 3-wire serial link (dout/load/clk).
- Supports a configurable digit count, serial clock divider and intensity.
- Sits between the clock/time formatter, which supplies raw segment bytes, and the off-chip display chain. Uses the same stb/busy/ack handshake.

---
 rtl/max7219_chain_driver.sv | 153 +++++++++++++++
 tb/tb_max7219_chain_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_chain_driver.sv
// Serial driver for a daisy-chain of MAX7219 display controllers.
// Sends either the five-frame configuration sequence or one frame per digit.
module max7219_chain_driver #(
  parameter int unsigned NUM_DEV    = 2,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_stb,
  input  logic                           i_write_config,
  input  logic [3:0]                     i_intensity,
  input  logic [NUM_DEV*NUM_DIGITS*8-1:0] i_segments,
  output logic                           o_busy,
  output logic                           o_ack,
  output logic                           o_serial_dout,
  output logic                           o_serial_load,
  output logic                           o_serial_clk
);

  localparam int unsigned WORD_BITS = NUM_DEV * 16;
  localparam int unsigned BIT_W     = $clog2(WORD_BITS);
  localparam int unsigned DIV_W     = $clog2(2 * CLK_DIV) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);
  localparam logic [2:0]       CFG_LAST   = 3'd4;
  localparam logic [2:0]       UPD_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]       SCAN_LIMIT = 8'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_GAP,
    S_DONE
  } state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [DIV_W-1:0]                r_div;
  logic [BIT_W-1:0]                r_bit;
  logic [2:0]                      r_frame;
  logic                            r_cfg;
  logic [3:0]                      r_intensity;
  logic [NUM_DEV*NUM_DIGITS*8-1:0] r_segments;

  logic                            w_accept;
  logic                            w_div_end;
  logic [BIT_W-1:0]                w_bit_sel;
  logic [15:0]                     w_cfg_word;
  logic [WORD_BITS-1:0]            w_frame;
  int unsigned                     w_digit;

  // DONE behaves like IDLE for acceptance so back-to-back requests lose no cycle
  assign w_accept  = i_stb && (r_state == S_IDLE || r_state == S_DONE);
  assign w_div_end = (r_div == DIV_LAST);
  assign w_bit_sel = BIT_LAST - r_bit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div       <= '0;
      r_bit       <= '0;
      r_frame     <= '0;
      r_cfg       <= 1'b0;
      r_intensity <= '0;
      r_segments  <= '0;
    end else if (w_accept) begin
      r_div       <= '0;
      r_bit       <= '0;
      r_frame     <= '0;
      r_cfg       <= i_write_config;
      r_intensity <= i_intensity;
      r_segments  <= i_segments;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            r_bit <= (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_LOAD: r_div <= w_div_end ? '0 : r_div + 1'b1;
        S_GAP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_frame <= r_frame + 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_stb) w_next = S_SHIFT;
      S_DONE:  w_next = i_stb ? S_SHIFT : S_IDLE;
      S_SHIFT: if (w_div_end && r_bit == BIT_LAST) w_next = S_LOAD;
      S_LOAD:  if (w_div_end) w_next = S_GAP;
      S_GAP: begin
        if (w_div_end) begin
          w_next = (r_frame == (r_cfg ? CFG_LAST : UPD_LAST)) ? S_DONE : S_SHIFT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Device d's word sits at [d*16 +: 16]; the top word leaves first and ends up farthest.
  always_comb begin
    w_digit = (r_frame <= UPD_LAST) ? 32'(r_frame) : 0;
    case (r_frame)
      3'd0:    w_cfg_word = 16'h0C01;
      3'd1:    w_cfg_word = 16'h0900;
      3'd2:    w_cfg_word = {8'h0B, SCAN_LIMIT};
      3'd3:    w_cfg_word = {8'h0A, 4'h0, r_intensity};
      default: w_cfg_word = 16'h0F00;
    endcase
    w_frame = '0;
    for (int unsigned d = 0; d < NUM_DEV; d++) begin
      if (r_cfg) begin
        w_frame[d*16 +: 16] = w_cfg_word;
      end else begin
        w_frame[d*16 +: 16] = {4'h0, {1'b0, r_frame} + 4'd1,
                               r_segments[(d*NUM_DIGITS + w_digit)*8 +: 8]};
      end
    end
  end

  always_comb begin
    o_busy        = (r_state == S_SHIFT) || (r_state == S_LOAD) || (r_state == S_GAP);
    o_ack         = (r_state == S_DONE);
    o_serial_dout = (r_state == S_SHIFT) && w_frame[w_bit_sel];
    o_serial_clk  = (r_state == S_SHIFT) && (r_div >= DIV_HALF);
    o_serial_load = (r_state == S_LOAD);
  end

endmodule

// File: tb/tb_max7219_chain_driver.sv
// Directed bench for max7219_chain_driver with a two-device MAX7219 chain model
// that shifts on rising serial clock and latches on rising load.
module tb_max7219_chain_driver;

  localparam int ND = 2;
  localparam int NG = 8;
  localparam int CD = 2;

  localparam logic [127:0] SEGS_A = 128'h474F3D4E1F777B7F_705F5B33796D307E;
  localparam logic [127:0] SEGS_B = 128'h0102040810204080_FEFDFBF7EFDFBF7F;
  localparam logic [127:0] SEGS_C = 128'h1122334455667788_99AABBCCDDEEFF00;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stb;
  logic                 wcfg;
  logic [3:0]           inten;
  logic [ND*NG*8-1:0]   segs;
  logic                 o_busy, o_ack, o_serial_dout, o_serial_load, o_serial_clk;

  always #5 clk = ~clk;

  max7219_chain_driver #(
    .NUM_DEV   (ND),
    .NUM_DIGITS(NG),
    .CLK_DIV   (CD)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_stb         (stb),
    .i_write_config(wcfg),
    .i_intensity   (inten),
    .i_segments    (segs),
    .o_busy        (o_busy),
    .o_ack         (o_ack),
    .o_serial_dout (o_serial_dout),
    .o_serial_load (o_serial_load),
    .o_serial_clk  (o_serial_clk)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // chain model and serial timing monitor, sampled on the falling system clock
  logic [31:0] sr = '0;
  logic [15:0] word;
  logic [7:0]  mem [ND][16];
  bit          mock_ready = 0;
  logic        p_sclk = 0, p_load = 0, p_dout = 0;
  int          edges = 0, hi_len = 0, lo_len = 0;
  int          bad_hi = 0, bad_lo = 0, bad_dout = 0, bad_load = 0;
  int          ack_count = 0;

  always @(negedge clk) begin
    if (!mock_ready) begin
      for (int d = 0; d < ND; d++)
        for (int a = 0; a < 16; a++) mem[d][a] = 8'hAA;
      mock_ready = 1;
    end
    if (o_ack === 1'b1) ack_count++;
    if (rst) begin
      edges  = 0;
      hi_len = 0;
      lo_len = 0;
    end else begin
      if (o_serial_clk) begin
        if (!p_sclk) begin
          if (edges != 0 && lo_len != CD) bad_lo++;
          hi_len = 1;
          edges++;
          sr = {sr[30:0], o_serial_dout};
        end else begin
          hi_len++;
          if (o_serial_dout !== p_dout) bad_dout++;
        end
      end else begin
        if (p_sclk) begin
          if (hi_len != CD) bad_hi++;
          lo_len = 1;
        end else begin
          lo_len++;
        end
      end
      if (o_serial_load && !p_load) begin
        if (edges != 32) bad_load++;
        edges = 0;
        for (int d = 0; d < ND; d++) begin
          word = sr[d*16 +: 16];
          mem[d][word[11:8]] = word[7:0];
        end
      end
    end
    p_sclk = o_serial_clk;
    p_load = o_serial_load;
    p_dout = o_serial_dout;
  end

  function automatic logic [127:0] mock_segs();
    logic [127:0] r;
    r = '0;
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < NG; k++) r[(d*NG+k)*8 +: 8] = mem[d][k+1];
    return r;
  endfunction

  function automatic logic [39:0] mock_cfg(input int d);
    return {mem[d][12], mem[d][9], mem[d][11], mem[d][10], mem[d][15]};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic cfg, input logic [3:0] it, input logic [127:0] sg);
    stb   = 1'b1;
    wcfg  = cfg;
    inten = it;
    segs  = sg;
    tick();
    stb   = 1'b0;
  endtask

  task automatic wait_ack(output int busy_cyc, output bit got);
    busy_cyc = 0;
    got      = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      if (o_ack) got = 1;
      else begin
        if (o_busy) busy_cyc++;
        tick();
      end
    end
  endtask

  initial begin
    int bc;
    bit ok;
    int a0;
    int extra;
    logic [127:0] pre;

    rst = 1'b1; stb = 1'b0; wcfg = 1'b0; inten = '0; segs = '0;
    repeat (3) tick();
    check("reset_outputs", {o_busy, o_ack, o_serial_dout, o_serial_load, o_serial_clk}, 5'b0);
    rst = 1'b0;
    tick();

    // configuration sequence
    a0 = ack_count;
    start(1'b1, 4'h7, SEGS_C);
    check("cfg_busy_rise", o_busy, 1'b1);
    wait_ack(bc, ok);
    check("cfg_ack_seen", ok, 1'b1);
    check("cfg_busy_cycles", bc, 680);
    check("cfg_ack_busy_low", o_busy, 1'b0);
    tick();
    check("cfg_ack_one_cycle", o_ack, 1'b0);
    check("cfg_ack_count", ack_count - a0, 1);
    check("cfg_dev0_regs", mock_cfg(0), 40'h0100070700);
    check("cfg_dev1_regs", mock_cfg(1), 40'h0100070700);

    // digit update
    start(1'b0, 4'h0, SEGS_A);
    wait_ack(bc, ok);
    check("upd_ack_seen", ok, 1'b1);
    check("upd_busy_cycles", bc, 1088);
    check("upd_digits", mock_segs(), SEGS_A);
    tick();

    // inputs changed and stb pulsed mid-transfer
    a0 = ack_count;
    start(1'b0, 4'h3, SEGS_B);
    repeat (200) tick();
    segs = SEGS_C; wcfg = 1'b1; inten = 4'h9; stb = 1'b1;
    tick();
    stb = 1'b0;
    wait_ack(bc, ok);
    check("snap_ack_seen", ok, 1'b1);
    check("snap_busy_rest", bc, 887);
    extra = 0;
    repeat (20) begin
      tick();
      if (o_busy) extra++;
    end
    check("snap_no_second", extra, 0);
    check("snap_ack_count", ack_count - a0, 1);
    check("snap_digits", mock_segs(), SEGS_B);

    // reset after 10 serial bits
    pre = mock_segs();
    a0  = ack_count;
    start(1'b0, 4'h0, SEGS_A);
    for (int n = 0; n < 500 && edges < 10; n++) tick();
    check("rst_bits_sent", edges, 10);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", {o_busy, o_ack, o_serial_dout, o_serial_load, o_serial_clk}, 5'b0);
    rst = 1'b0;
    repeat (10) tick();
    check("rst_mock_kept", mock_segs(), pre);
    check("rst_no_ack", ack_count - a0, 0);
    start(1'b0, 4'h0, SEGS_A);
    wait_ack(bc, ok);
    check("rst_after_busy", bc, 1088);
    check("rst_after_digits", mock_segs(), SEGS_A);
    tick();

    // back-to-back with stb held through the ack cycle
    a0 = ack_count;
    stb = 1'b1; wcfg = 1'b0; segs = SEGS_C;
    tick();
    wait_ack(bc, ok);
    check("b2b_first_ack", ok, 1'b1);
    check("b2b_first_busy", bc, 1088);
    segs = SEGS_B;
    tick();
    check("b2b_busy_again", o_busy, 1'b1);
    check("b2b_ack_dropped", o_ack, 1'b0);
    stb = 1'b0;
    segs = SEGS_A;
    wait_ack(bc, ok);
    check("b2b_second_ack", ok, 1'b1);
    check("b2b_second_busy", bc, 1088);
    check("b2b_digits", mock_segs(), SEGS_B);
    check("b2b_ack_count", ack_count - a0, 2);
    tick();

    // config with a different intensity
    start(1'b1, 4'hA, '0);
    wait_ack(bc, ok);
    check("cfg2_busy_cycles", bc, 680);
    check("cfg2_dev0_regs", mock_cfg(0), 40'h0100070A00);
    check("cfg2_dev1_regs", mock_cfg(1), 40'h0100070A00);
    check("cfg2_digits_kept", mock_segs(), SEGS_B);
    tick();

    check("timing_high_phase", bad_hi, 0);
    check("timing_low_phase", bad_lo, 0);
    check("timing_dout_stable", bad_dout, 0);
    check("timing_load_after_32", bad_load, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
